// File: rtl/ibex_clic_arbiter_if.sv
// Bus between the CLIC arbiter and its environment: source lines, config writes,
// the request/claim/complete handshake and the presented interrupt triple.
interface ibex_clic_arbiter_if #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_IRQ)
);
  logic [NUM_IRQ-1:0] irq_src_i;
  logic               cfg_we_i;
  logic [IDX_W-1:0]   cfg_idx_i;
  logic [7:0]         cfg_prio_i;
  logic               cfg_en_i;
  logic               thr_we_i;
  logic [7:0]         thr_i;
  logic               ack_i;
  logic               complete_i;
  logic               clic_irq_o;
  logic [11:0]        clic_irq_id_o;
  logic [7:0]         clic_irq_priority_o;
  logic [7:0]         clic_threshold_o;
  logic               clic_claim_o;
  logic               busy_o;

  modport slave (
    input  irq_src_i, cfg_we_i, cfg_idx_i, cfg_prio_i, cfg_en_i,
           thr_we_i, thr_i, ack_i, complete_i,
    output clic_irq_o, clic_irq_id_o, clic_irq_priority_o,
           clic_threshold_o, clic_claim_o, busy_o
  );

  modport master (
    output irq_src_i, cfg_we_i, cfg_idx_i, cfg_prio_i, cfg_en_i,
           thr_we_i, thr_i, ack_i, complete_i,
    input  clic_irq_o, clic_irq_id_o, clic_irq_priority_o,
           clic_threshold_o, clic_claim_o, busy_o
  );
endinterface

// File: rtl/ibex_clic_arbiter.sv
// Edge-latching interrupt arbiter: picks the highest-priority eligible source and
// sequences request -> claim -> complete so only one interrupt is in service.
module ibex_clic_arbiter #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ibex_clic_arbiter_if.slave bus
);

  localparam int unsigned PRIO_W = 8;
  localparam int unsigned ID_W   = 12;
  localparam int unsigned IDXP_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  src_q, src_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  en_q, en_d;
  logic [PRIO_W-1:0]   prio_q [NUM_IRQ];
  logic [PRIO_W-1:0]   prio_d [NUM_IRQ];
  logic [PRIO_W-1:0]   thr_q, thr_d;
  logic [IDX_W-1:0]    sel_id_q, sel_id_d;
  logic [PRIO_W-1:0]   sel_prio_q, sel_prio_d;
  logic                irq_q, irq_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;
  logic [PRIO_W-1:0]   irq_prio_q, irq_prio_d;
  logic                claim_q, claim_d;
  logic                busy_q, busy_d;

  logic [NUM_IRQ-1:0]  eligible_c;
  logic                any_eligible_c;
  logic [IDX_W-1:0]    best_id_c;
  logic [PRIO_W-1:0]   best_prio_c;
  logic                sel_still_ok_c;

  // Winner scan: strict '>' keeps the lowest index on priority ties.
  always_comb begin
    eligible_c     = '0;
    any_eligible_c = 1'b0;
    best_id_c      = '0;
    best_prio_c    = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      eligible_c[i] = pending_q[i] & en_q[i] & (prio_q[i] > thr_q);
      if (eligible_c[i] && (!any_eligible_c || (prio_q[i] > best_prio_c))) begin
        any_eligible_c = 1'b1;
        best_id_c      = IDX_W'(i);
        best_prio_c    = prio_q[i];
      end
    end
  end

  // Configuration and threshold registers; out-of-range indices are dropped.
  always_comb begin
    en_d   = en_q;
    prio_d = prio_q;
    thr_d  = thr_q;
    if (bus.cfg_we_i && ({1'b0, bus.cfg_idx_i} < IDXP_W'(NUM_IRQ))) begin
      prio_d[bus.cfg_idx_i] = bus.cfg_prio_i;
      en_d[bus.cfg_idx_i]   = bus.cfg_en_i;
    end
    if (bus.thr_we_i) begin
      thr_d = bus.thr_i;
    end
  end

  assign sel_still_ok_c = en_q[sel_id_q] & (sel_prio_q > thr_q);

  // Handshake sequencer; a new edge on the claimed source re-sets pending.
  always_comb begin
    state_d    = state_q;
    sel_id_d   = sel_id_q;
    sel_prio_d = sel_prio_q;
    claim_d    = 1'b0;
    pending_d  = pending_q;
    src_d      = bus.irq_src_i;

    unique case (state_q)
      IDLE: begin
        if (any_eligible_c) begin
          sel_id_d   = best_id_c;
          sel_prio_d = best_prio_c;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.ack_i) begin
          pending_d[sel_id_q] = 1'b0;
          claim_d             = 1'b1;
          state_d             = ACTIVE;
        end else if (!sel_still_ok_c) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (bus.complete_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d  = pending_d | (bus.irq_src_i & ~src_q);

    irq_d      = (state_d == REQ);
    busy_d     = (state_d == ACTIVE);
    irq_id_d   = irq_d ? ID_W'(sel_id_d) : '0;
    irq_prio_d = irq_d ? sel_prio_d : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      src_q      <= '0;
      pending_q  <= '0;
      en_q       <= '0;
      thr_q      <= '0;
      sel_id_q   <= '0;
      sel_prio_q <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      irq_prio_q <= '0;
      claim_q    <= 1'b0;
      busy_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        prio_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      pending_q  <= pending_d;
      en_q       <= en_d;
      thr_q      <= thr_d;
      sel_id_q   <= sel_id_d;
      sel_prio_q <= sel_prio_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      irq_prio_q <= irq_prio_d;
      claim_q    <= claim_d;
      busy_q     <= busy_d;
      prio_q     <= prio_d;
    end
  end

  assign bus.clic_irq_o          = irq_q;
  assign bus.clic_irq_id_o       = irq_id_q;
  assign bus.clic_irq_priority_o = irq_prio_q;
  assign bus.clic_threshold_o    = thr_q;
  assign bus.clic_claim_o        = claim_q;
  assign bus.busy_o              = busy_q;

endmodule

// File: tb/tb_ibex_clic_arbiter.sv
// Bench for ibex_clic_arbiter: constant-vector table, directed corner sequences,
// and random traffic compared every cycle against a transaction-level model.
module tb_ibex_clic_arbiter;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_clic_arbiter_if #(.NUM_IRQ(N)) bus ();

  ibex_clic_arbiter #(.NUM_IRQ(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: what has happened so far, in plain integers.
  bit [N-1:0] m_src, m_pend, m_en;
  int         m_prio [N];
  int         m_thr;
  int         m_mode;      // 0 waiting, 1 offering, 2 servicing
  int         m_sel, m_selp;
  bit         m_claim;

  typedef struct {
    logic [N-1:0] src;
    logic         ack;
    logic         cmp;
    int           irq;
    int           id;
    int           prio;
    int           claim;
    int           busy;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src = '0; m_pend = '0; m_en = '0; m_thr = 0;
    m_mode = 0; m_sel = 0; m_selp = 0; m_claim = 0;
    for (int i = 0; i < N; i++) m_prio[i] = 0;
  endtask

  function automatic bit elig(input int i);
    return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
  endfunction

  // Highest priority wins; among equals the first index found.
  function automatic int pick();
    int top = -1;
    for (int i = 0; i < N; i++) if (elig(i) && m_prio[i] > top) top = m_prio[i];
    if (top < 0) return -1;
    for (int i = 0; i < N; i++) if (elig(i) && m_prio[i] == top) return i;
    return -1;
  endfunction

  task automatic model_step(input bit [N-1:0] src, input bit ack, input bit cmp,
                            input bit cwe, input int cidx, input int cprio, input bit cen,
                            input bit twe, input int tval);
    int nmode = m_mode;
    int w;
    bit [N-1:0] rises = src & ~m_src;
    m_claim = 0;
    if (m_mode == 0) begin
      w = pick();
      if (w >= 0) begin m_sel = w; m_selp = m_prio[w]; nmode = 1; end
    end else if (m_mode == 1) begin
      if (ack) begin m_pend[m_sel] = 0; m_claim = 1; nmode = 2; end
      else if (!(m_en[m_sel] && m_selp > m_thr)) nmode = 0;
    end else if (cmp) begin
      nmode = 0;
    end
    m_pend |= rises;
    if (cwe && cidx < N) begin m_prio[cidx] = cprio; m_en[cidx] = cen; end
    if (twe) m_thr = tval;
    m_src  = src;
    m_mode = nmode;
  endtask

  task automatic cmp_model();
    bit irq = (m_mode == 1);
    chk("m_irq",   int'(bus.clic_irq_o),          int'(irq));
    chk("m_id",    int'(bus.clic_irq_id_o),       irq ? m_sel : 0);
    chk("m_prio",  int'(bus.clic_irq_priority_o), irq ? m_selp : 0);
    chk("m_thr",   int'(bus.clic_threshold_o),    m_thr);
    chk("m_claim", int'(bus.clic_claim_o),        int'(m_claim));
    chk("m_busy",  int'(bus.busy_o),              int'(m_mode == 2));
  endtask

  // One clock: inputs as driven now are what the edge samples.
  task automatic tick();
    bit [N-1:0] s = bus.irq_src_i;
    bit a = bus.ack_i, c = bus.complete_i, cw = bus.cfg_we_i, ce = bus.cfg_en_i, tw = bus.thr_we_i;
    int ci = int'(bus.cfg_idx_i), cp = int'(bus.cfg_prio_i), tv = int'(bus.thr_i);
    @(posedge clk);
    #1;
    model_step(s, a, c, cw, ci, cp, ce, tw, tv);
    cmp_model();
  endtask

  task automatic set_cfg(input int idx, input int p, input bit en);
    bus.cfg_we_i = 1; bus.cfg_idx_i = 4'(idx); bus.cfg_prio_i = 8'(p); bus.cfg_en_i = en;
    tick();
    bus.cfg_we_i = 0;
  endtask

  task automatic set_thr(input int v);
    bus.thr_we_i = 1; bus.thr_i = 8'(v);
    tick();
    bus.thr_we_i = 0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    bus.irq_src_i = m;
    tick();
    bus.irq_src_i = '0;
  endtask

  task automatic do_ack();    bus.ack_i = 1;      tick(); bus.ack_i = 0;      endtask
  task automatic do_cmp();    bus.complete_i = 1; tick(); bus.complete_i = 0; endtask

  task automatic expect_req(input string name, input int id, input int p);
    chk({name, "_irq"},  int'(bus.clic_irq_o), 1);
    chk({name, "_id"},   int'(bus.clic_irq_id_o), id);
    chk({name, "_prio"}, int'(bus.clic_irq_priority_o), p);
  endtask

  initial begin
    bus.irq_src_i = '0; bus.cfg_we_i = 0; bus.cfg_idx_i = '0; bus.cfg_prio_i = '0;
    bus.cfg_en_i = 0; bus.thr_we_i = 0; bus.thr_i = '0; bus.ack_i = 0; bus.complete_i = 0;
    model_reset();

    tbl[0] = '{src: 16'h0008, ack: 0, cmp: 0, irq: 0, id: 0, prio: 0, claim: 0, busy: 0};
    tbl[1] = '{src: 16'h0008, ack: 0, cmp: 0, irq: 1, id: 3, prio: 5, claim: 0, busy: 0};
    tbl[2] = '{src: 16'h0000, ack: 1, cmp: 0, irq: 0, id: 0, prio: 0, claim: 1, busy: 1};
    tbl[3] = '{src: 16'h0000, ack: 0, cmp: 0, irq: 0, id: 0, prio: 0, claim: 0, busy: 1};
    tbl[4] = '{src: 16'h0000, ack: 0, cmp: 1, irq: 0, id: 0, prio: 0, claim: 0, busy: 0};
    tbl[5] = '{src: 16'h0000, ack: 0, cmp: 0, irq: 0, id: 0, prio: 0, claim: 0, busy: 0};

    #12;
    chk("rst_irq",   int'(bus.clic_irq_o), 0);
    chk("rst_id",    int'(bus.clic_irq_id_o), 0);
    chk("rst_thr",   int'(bus.clic_threshold_o), 0);
    chk("rst_claim", int'(bus.clic_claim_o), 0);
    chk("rst_busy",  int'(bus.busy_o), 0);
    @(posedge clk); #1; rst = 0;

    // Single source 3 through the full handshake.
    set_cfg(3, 5, 1);
    for (int v = 0; v < 6; v++) begin
      bus.irq_src_i = tbl[v].src; bus.ack_i = tbl[v].ack; bus.complete_i = tbl[v].cmp;
      tick();
      chk($sformatf("t%0d_irq", v),   int'(bus.clic_irq_o),          tbl[v].irq);
      chk($sformatf("t%0d_id", v),    int'(bus.clic_irq_id_o),       tbl[v].id);
      chk($sformatf("t%0d_prio", v),  int'(bus.clic_irq_priority_o), tbl[v].prio);
      chk($sformatf("t%0d_claim", v), int'(bus.clic_claim_o),        tbl[v].claim);
      chk($sformatf("t%0d_busy", v),  int'(bus.busy_o),              tbl[v].busy);
    end
    bus.ack_i = 0; bus.complete_i = 0; bus.irq_src_i = '0;

    // Priority order and lowest-index tie break.
    set_cfg(2, 4, 1); set_cfg(7, 9, 1); set_cfg(1, 6, 1); set_cfg(5, 6, 1);
    pulse(16'h0084); tick();
    expect_req("pri_hi", 7, 9);
    do_ack(); do_cmp();
    chk("gap_idle", int'(bus.clic_irq_o), 0);
    tick();
    expect_req("pri_lo", 2, 4);
    do_ack(); do_cmp();
    pulse(16'h0022); tick();
    expect_req("tie", 1, 6);
    do_ack(); do_cmp(); tick();
    expect_req("tie2", 5, 6);
    do_ack(); do_cmp();

    // Threshold is a strict compare.
    set_thr(5); pulse(16'h0008); tick(); tick();
    chk("thr_eq_block", int'(bus.clic_irq_o), 0);
    set_thr(4);
    chk("thr_w_edge", int'(bus.clic_irq_o), 0);
    tick();
    expect_req("thr_open", 3, 5);

    // Withdraw on threshold raise, pending kept.
    set_thr(8);
    chk("wd_hold", int'(bus.clic_irq_o), 1);
    tick();
    chk("wd_drop", int'(bus.clic_irq_o), 0);
    set_thr(0); tick();
    expect_req("wd_back", 3, 5);
    do_ack(); do_cmp(); tick();

    // No preemption, set-wins on claim, ack ignored when idle.
    set_cfg(4, 3, 1);
    pulse(16'h0010); tick();
    expect_req("np_4", 4, 3);
    pulse(16'h0080); tick();
    expect_req("np_hold", 4, 3);
    bus.irq_src_i = 16'h0010; bus.ack_i = 1; tick();
    bus.irq_src_i = '0; bus.ack_i = 0;
    chk("sw_claim", int'(bus.clic_claim_o), 1);
    chk("sw_busy",  int'(bus.busy_o), 1);
    do_cmp(); tick();
    expect_req("sw_7", 7, 9);
    do_ack(); do_cmp(); tick();
    expect_req("sw_4again", 4, 3);
    do_ack(); do_cmp(); tick();
    do_ack();
    chk("idle_ack_claim", int'(bus.clic_claim_o), 0);
    chk("idle_ack_busy",  int'(bus.busy_o), 0);

    // Asynchronous reset while servicing with events pending.
    pulse(16'h0008); tick(); do_ack(); pulse(16'h0080);
    chk("pre_rst_busy", int'(bus.busy_o), 1);
    #2 rst = 1;
    #1;
    chk("arst_irq",   int'(bus.clic_irq_o), 0);
    chk("arst_id",    int'(bus.clic_irq_id_o), 0);
    chk("arst_prio",  int'(bus.clic_irq_priority_o), 0);
    chk("arst_thr",   int'(bus.clic_threshold_o), 0);
    chk("arst_claim", int'(bus.clic_claim_o), 0);
    chk("arst_busy",  int'(bus.busy_o), 0);
    model_reset();
    @(posedge clk); #1; rst = 0;
    set_cfg(3, 5, 1); set_cfg(7, 9, 1); tick(); tick();
    chk("post_rst_quiet", int'(bus.clic_irq_o), 0);
    pulse(16'h0008); tick();
    expect_req("post_rst_new", 3, 5);
    do_ack(); do_cmp(); tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.irq_src_i  = bus.irq_src_i ^ N'($urandom & $urandom & $urandom);
      bus.ack_i      = ($urandom % 3) == 0;
      bus.complete_i = ($urandom % 4) == 0;
      bus.cfg_we_i   = ($urandom % 6) == 0;
      bus.cfg_idx_i  = 4'($urandom);
      bus.cfg_prio_i = 8'($urandom % 8);
      bus.cfg_en_i   = ($urandom % 4) != 0;
      bus.thr_we_i   = ($urandom % 16) == 0;
      bus.thr_i      = 8'($urandom % 4);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_clic_arbiter.md
# ibex_clic_arbiter

Interrupt arbiter and sequencer in front of the Ibex CLIC wrapper. It latches edge-triggered requests from `NUM_IRQ` sources and holds a per-source priority and enable plus a global threshold. It selects the highest-priority eligible source and presents it as a single request/ID/priority triple, then sequences the request → claim → complete handshake so that only one interrupt is in service at a time.

## Interface
Parameters:
- `NUM_IRQ`, 16: number of interrupt sources (2..64).
- `IDX_W`, `$clog2(NUM_IRQ)`: source index width (derived; do not override).

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `irq_src_i`  in  NUM_IRQ  raw source lines; rising edge = event.
- `cfg_we_i`  in  1  per-source config write strobe.
- `cfg_idx_i`  in  IDX_W  source index for config write.
- `cfg_prio_i`  in  8  priority to write.
- `cfg_en_i`  in  1  enable to write.
- `thr_we_i`  in  1  threshold write strobe.
- `thr_i`  in  8  threshold value.
- `ack_i`  in  1  core accepts the presented interrupt.
- `complete_i`  in  1  core finished servicing the in-service interrupt.
- `clic_irq_o`  out  1  request valid; drives the wrapper's `clic_irq_i`.
- `clic_irq_id_o`  out  12  selected source index, zero-extended.
- `clic_irq_priority_o`  out  8  selected source priority.
- `clic_threshold_o`  out  8  current threshold register.
- `clic_claim_o`  out  1  one-cycle pulse on accepted ack.
- `busy_o`  out  1  an interrupt is in service.

## Operation
- Edge detect: `src_q` registers `irq_src_i`. `pending[i]` is set when `irq_src_i[i] & ~src_q[i]`. It is cleared only when that source is claimed. If a set and a clear hit the same cycle, set wins.
- Eligible(i) = `pending[i] & en[i] & (prio[i] > thr)`, with a strict comparison.
- Selection: the highest `prio` among eligible sources. Ties go to the lowest index. The selection logic is combinational from registered state.
- Config: `cfg_we_i` writes `prio[cfg_idx_i]` and `en[cfg_idx_i]`. The write is ignored if `cfg_idx_i >= NUM_IRQ`. `thr_we_i` writes `thr`. Both writes take effect the next cycle.
- FSM states:
  - IDLE: if any source is eligible, register its index and priority into `sel_id` and `sel_prio`, then go to REQ.
  - REQ: `clic_irq_o`=1, and `sel_id`/`sel_prio` are held stable even if a higher-priority source arrives (no preemption).
    - On `ack_i`: clear `pending[sel_id]`, pulse `clic_claim_o`, go to ACTIVE.
    - Otherwise, if the selected source is no longer eligible (disabled, or `thr` >= `sel_prio`): withdraw to IDLE, `pending` unchanged.
    - If `ack_i` and withdraw occur in the same cycle, `ack_i` wins.
  - ACTIVE: `busy_o`=1 and `clic_irq_o`=0. New events keep accumulating in `pending`. On `complete_i`, go to IDLE.
- `ack_i` is ignored outside REQ. `complete_i` is ignored outside ACTIVE.
- `clic_irq_id_o` = `{'0, sel_id}`. `clic_irq_priority_o` = `sel_prio`. Both read 0 whenever the state is not REQ.

## Timing
- Reset values:
  - State IDLE.
  - `pending`, `src_q`, `prio`, `en`, `thr` are all 0.
  - All outputs are 0 (`clic_irq_o`, `clic_irq_id_o`, `clic_irq_priority_o`, `clic_threshold_o`, `clic_claim_o`, `busy_o`).
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). In-service state is lost with no claim pulse.
- Latency:
  - Source rises before edge k: `pending` is set at edge k, REQ is entered at edge k+1, so `clic_irq_o`=1 after edge k+1 (2 cycles).
  - `ack_i` sampled at edge m: `clic_claim_o`=1 for exactly the cycle after m. `busy_o`=1 from edge m.
  - `complete_i` at edge n: IDLE from n. A pending eligible source re-enters REQ at edge n+1, so there is one idle cycle minimum between services.
- Threshold or enable write at edge w: eligibility uses the new value from cycle w onward, and a withdraw from REQ happens at edge w+1.
- A source held high generates one event only. A re-arm needs a low cycle.

## Test plan
- Single source 3, `prio`=5, en=1, thr=0. Pulse source → `clic_irq_o` rises 2 cycles later with id=3, prio=5. Ack → claim pulse of 1 cycle, `busy_o`=1. Complete → idle, `pending[3]`=0.
- Sources 2 (prio 4) and 7 (prio 9) rise together → id=7 presented. After complete, id=2 is presented. Then sources 1 and 5, both prio 6 → id=1 first.
- Threshold: `prio`=5, `thr`=5, event → no request. Write `thr`=4 → request appears next cycle +1.
- In REQ for id 3 (prio 5), write `thr`=8 → `clic_irq_o` drops at the next edge and `pending[3]` stays 1. Write `thr`=0 → id 3 is re-presented.
- In REQ for id 4: new event on id 4 in the same cycle as `ack_i` → claim proceeds and `pending[4]` remains 1. A higher-priority event during REQ does not change the outputs. `ack_i` in IDLE has no effect.
- Assert `rst_i` during ACTIVE with pending events → all outputs are 0 immediately. After release, no request is made until a new rising edge.
